// File: rtl/serial_pkg.sv
// Shared types and helpers for the serial transmitter.
package serial_pkg;

  // Transmitter frame states.
  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  // Counter width for a modulus of n, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bit_timer.sv
// Bit-period divider: tick marks the last clk cycle of each bit period.
module bit_timer
  import serial_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CntW = cnt_width(CLKS_PER_BIT);
  localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] count;

  assign tick = (count == LastCnt);

  // Count 0..CLKS_PER_BIT-1 and wrap on tick; clear holds the count at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear || tick) begin
      count <= '0;
    end else begin
      count <= count + CntW'(1);
    end
  end

endmodule

// File: rtl/serial_tx.sv
// Serial transmitter: start bit, DATA_W data bits LSB first, one stop bit.
module serial_tx
  import serial_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx,
  output logic              busy
);

  localparam int unsigned BitW = $clog2(DATA_W + 1);
  localparam logic [BitW-1:0] LastBit = BitW'(DATA_W - 1);

  state_t            state;
  logic [BitW-1:0]   bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_shift;
  logic              tick;
  logic              timer_clear;

  assign tx_ready    = (state == IDLE);
  assign busy        = (state != IDLE);
  // Holding the timer cleared in IDLE makes START start at count zero.
  assign timer_clear = (state == IDLE);
  assign shreg_shift = shreg >> 1;

  bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk   (clk),
    .reset (reset),
    .clear (timer_clear),
    .tick  (tick)
  );

  // Frame FSM; tx is registered from the next state so it never glitches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      tx      <= 1'b1;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (tx_valid) begin
            shreg <= tx_data;
            state <= START;
            tx    <= 1'b0;
          end
        end
        START: begin
          if (tick) begin
            state   <= DATA;
            tx      <= shreg[0];
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (tick) begin
            shreg <= shreg_shift;
            if (bit_cnt == LastBit) begin
              state   <= STOP;
              tx      <= 1'b1;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + BitW'(1);
              tx      <= shreg_shift[0];
            end
          end
        end
        STOP: begin
          if (tick) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule
